kpn_fifo_channel: RTL and testbench
===================================

# kpn_fifo_channel

Parametrised, single-clock FIFO for one Kahn Process Network channel. It replaces the fixed 16-bit FIFO with configurable width and depth, full/empty/almost-full flags, an occupancy count, and a high-water mark used to size KPN buffers. Error flags are sticky. It sits between a producer process (`wr` side) and a consumer process (`rd` side) in every KPN graph.

## Interface
Parameters:
- `WIDTH`, 16, data width in bits (≥1).
- `DEPTH`, 8, number of entries; power of two, ≥2.
- `AF_LEVEL`, DEPTH-2, `almost_full` asserts when `count >= AF_LEVEL`.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `wr` input 1: write request.
- `entry_1` input WIDTH: write data, sampled with `wr`.
- `rd` input 1: read request.
- `output_1` output WIDTH: registered read data.
- `out_valid` output 1: one-cycle pulse, `output_1` updated by an accepted read.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `almost_full` output 1: count ≥ AF_LEVEL.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `high_water` output $clog2(DEPTH)+1: maximum count since reset or clear.
- `hw_clear` input 1: resets `high_water` to the current `count`.
- `overflow` output 1: sticky; a write was attempted while full and no read was accepted.
- `underflow` output 1: sticky; a read was attempted while empty.

## Operation
- Storage is a DEPTH×WIDTH array with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits. Pointers wrap naturally modulo DEPTH.
- Write acceptance: `wr_ok = wr & (!full | rd_ok)`.
- Read acceptance: `rd_ok = rd & !empty`.
- There is no fall-through. A write into an empty FIFO cannot be read in the same cycle.
- Full with `rd` and `wr` both high: both are accepted and `count` is unchanged.
- Empty with `rd` and `wr` both high: only the write is accepted, and `underflow` sets.
- Full with `wr` high and `rd` low: the write is dropped, `overflow` sets, and storage is unchanged.
- Accepted read: `output_1 <= mem[rp]`, `rp++`, and `out_valid` pulses.
- Otherwise `output_1` holds its previous value and `out_valid` = 0.
- Count update: `count <= count + wr_ok - rd_ok`. Flags are derived combinationally from the registered `count`.
- High-water mark: `high_water <= max(high_water, next_count)`. When `hw_clear` is high it loads `next_count` instead.
- `overflow` and `underflow` clear only on reset.
- Reset values (`rst_n` low at an edge): `wp`=`rp`=0, `count`=0, `output_1`=0, `out_valid`=0, `high_water`=0, `overflow`=`underflow`=0.
  - Flags after reset: `empty`=1, `full`=0, `almost_full`=0 (for AF_LEVEL>0).
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. Reset has priority over `rd` and `wr` in the same cycle.

## Timing
- Write-to-visible latency: a write accepted at edge N updates `count` and `empty` after edge N. The earliest read is accepted at edge N+1, and `output_1` is valid after N+1.
- Read latency: 1 cycle from the accepting edge to `output_1`/`out_valid`.
- Throughput: one write and one read per cycle sustained, including while full.
- Flags and `count` change only at clock edges. They are never combinational from `rd`/`wr`.

## Structure
- Package `kpn_pkg` holds:
  - the `clog2`-based width constant function,
  - the `kpn_data_t` typedef for the default 16-bit token,
  - the default `KPN_FIFO_DEPTH`.
- One sub-module, `kpn_fifo_mem`: a simple dual-port array (synchronous write, synchronous read with read-enable) so it can map to block RAM.
- Pointers, count, flags and high-water logic live in the top module.

## Test plan
- Reset and basic order: after reset `empty`=1 and `count`=0. Write 10, 20, 30, then read ×3. Expect `output_1` = 10, 20, 30 with one `out_valid` pulse each, and `empty`=1 at the end.
- Fill, wrap and overflow (DEPTH=8):
  - Write values 1..8: `full`=1, `almost_full` from count 6.
  - Write 9 with no read: dropped, `overflow`=1.
  - Read 8 values: expect 1..8.
  - Write and read 8 more: pointers wrap and data stays correct.
- Simultaneous access:
  - While full, `rd`+`wr` with 99: `count` stays 8, the oldest value is output, and 99 is read last.
  - While empty, `rd`+`wr` with 5: `underflow`=1, `count`=1, and the next read returns 5.
- Underflow on idle: `rd` while empty leaves `output_1` unchanged, no `out_valid`, `underflow` sticky until reset.
- High-water mark: write 5, read 5 → `high_water`=5. Pulse `hw_clear` → 0. Write 2 → `high_water`=2.
- Reset mid-stream: with 4 entries stored, pull `rst_n` low for one cycle while `wr`=1. Expect every output at its reset value and the write not stored. The next write then reads back correctly.

Source files
------------

// File: rtl/kpn_pkg.sv
// Shared types and sizing helpers for Kahn Process Network channel FIFOs.
package kpn_pkg;

    localparam int KPN_FIFO_DEPTH = 8;

    typedef logic [15:0] kpn_data_t;

    // Occupancy counters need one extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int kpn_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/kpn_fifo_mem.sv
// Simple dual-port storage array: synchronous write, registered read with read enable.
module kpn_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The output register is the only part that is reset; the array itself is not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/kpn_fifo_channel.sv
// Single-clock KPN channel FIFO with occupancy count, high-water mark and sticky error flags.
module kpn_fifo_channel
    import kpn_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = KPN_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr,
    input  logic [WIDTH-1:0]              entry_1,
    input  logic                          rd,
    output logic [WIDTH-1:0]              output_1,
    output logic                          out_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic [kpn_cnt_w(DEPTH)-1:0]   count,
    output logic [kpn_cnt_w(DEPTH)-1:0]   high_water,
    input  logic                          hw_clear,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = kpn_cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [AW-1:0] wp_reg, rp_reg;
    logic [CW-1:0] count_reg, count_next, hw_reg;
    logic          out_valid_reg, overflow_reg, underflow_reg;
    logic          rd_ok, wr_ok;

    // Flags come only from the registered count, never from rd/wr.
    assign full        = (count_reg == DEPTH_C);
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= AF_C);

    // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside a read.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    assign count_next = count_reg + CW'(wr_ok) - CW'(rd_ok);

    kpn_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok & rst_n),
        .waddr (wp_reg),
        .wdata (entry_1),
        .re    (rd_ok),
        .raddr (rp_reg),
        .rdata (output_1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_reg        <= '0;
            rp_reg        <= '0;
            count_reg     <= '0;
            hw_reg        <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp_reg <= wp_reg + 1'b1;
            end
            if (rd_ok) begin
                rp_reg <= rp_reg + 1'b1;
            end
            count_reg     <= count_next;
            out_valid_reg <= rd_ok;
            if (hw_clear || (count_next > hw_reg)) begin
                hw_reg <= count_next;
            end
            if (wr && full && !rd_ok) begin
                overflow_reg <= 1'b1;
            end
            if (rd && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign count      = count_reg;
    assign high_water = hw_reg;
    assign out_valid  = out_valid_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed bench for kpn_fifo_channel at WIDTH=16, DEPTH=8, AF_LEVEL=6.
module tb_kpn_fifo_channel;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] entry_1 = '0;
    logic        rd = 1'b0;
    logic        hw_clear = 1'b0;
    logic [15:0] output_1;
    logic        out_valid, full, empty, almost_full, overflow, underflow;
    logic [3:0]  count, high_water;

    int checks = 0;
    int fails  = 0;

    kpn_fifo_channel #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr),
        .entry_1     (entry_1),
        .rd          (rd),
        .output_1    (output_1),
        .out_valid   (out_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .high_water  (high_water),
        .hw_clear    (hw_clear),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic hc);
        wr = w; entry_1 = d; rd = r; hw_clear = hc;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; hw_clear = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_af"}, 32'(almost_full), 0);
        chk({tag, "_out"}, 32'(output_1), 0);
        chk({tag, "_ovalid"}, 32'(out_valid), 0);
        chk({tag, "_hw"}, 32'(high_water), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_udf"}, 32'(underflow), 0);
    endtask

    task automatic rd_expect(input string tag, input logic [15:0] v);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk({tag, "_data"}, 32'(output_1), 32'(v));
        chk({tag, "_ovalid"}, 32'(out_valid), 1);
        $display("read %s: output_1=%0d out_valid=%0b count=%0d", tag, output_1, out_valid, count);
    endtask

    initial begin
        // Reset and basic order
        rst_n = 1'b0;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk_reset_state("rst");
        cyc(1'b1, 16'd10, 1'b0, 1'b0);
        chk("wr10_empty", 32'(empty), 0);
        chk("wr10_ovalid", 32'(out_valid), 0);
        cyc(1'b1, 16'd20, 1'b0, 1'b0);
        cyc(1'b1, 16'd30, 1'b0, 1'b0);
        chk("basic_count", 32'(count), 3);
        rd_expect("basic0", 16'd10);
        rd_expect("basic1", 16'd20);
        rd_expect("basic2", 16'd30);
        chk("basic_empty", 32'(empty), 1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("idle_ovalid", 32'(out_valid), 0);
        chk("idle_hold", 32'(output_1), 30);
        chk("basic_hw", 32'(high_water), 3);

        // Fill, almost_full threshold, overflow
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 16'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d_af", i), 32'(almost_full), (i >= 6) ? 1 : 0);
            chk($sformatf("fill%0d_full", i), 32'(full), (i == 8) ? 1 : 0);
            $display("write %0d: count=%0d af=%0b full=%0b", i, count, almost_full, full);
        end
        chk("fill_ovf_pre", 32'(overflow), 0);
        cyc(1'b1, 16'd9, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 1; i <= 8; i++) rd_expect($sformatf("drain%0d", i), 16'(i));
        chk("drain_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);

        // Pointer wrap
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(11 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) rd_expect($sformatf("wrap%0d", i), 16'(11 + i));

        // Simultaneous read/write while full
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(21 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'd99, 1'b1, 1'b0);
        chk("fullrw_data", 32'(output_1), 21);
        chk("fullrw_ovalid", 32'(out_valid), 1);
        chk("fullrw_count", 32'(count), 8);
        for (int i = 0; i < 7; i++) rd_expect($sformatf("fullrw%0d", i), 16'(22 + i));
        rd_expect("fullrw_last", 16'd99);
        chk("fullrw_empty", 32'(empty), 1);
        chk("udf_pre", 32'(underflow), 0);

        // Simultaneous read/write while empty
        cyc(1'b1, 16'd5, 1'b1, 1'b0);
        chk("emptyrw_udf", 32'(underflow), 1);
        chk("emptyrw_count", 32'(count), 1);
        chk("emptyrw_ovalid", 32'(out_valid), 0);
        chk("emptyrw_hold", 32'(output_1), 99);
        rd_expect("emptyrw", 16'd5);

        // Read on idle empty FIFO
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("idleudf_ovalid", 32'(out_valid), 0);
        chk("idleudf_hold", 32'(output_1), 5);
        chk("idleudf_udf", 32'(underflow), 1);
        chk("idleudf_count", 32'(count), 0);

        // High-water mark
        chk("hw_before", 32'(high_water), 8);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("hw_clr0", 32'(high_water), 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) rd_expect($sformatf("hw%0d", i), 16'(40 + i));
        chk("hw_five", 32'(high_water), 5);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("hw_clr1", 32'(high_water), 0);
        cyc(1'b1, 16'd50, 1'b0, 1'b0);
        cyc(1'b1, 16'd51, 1'b0, 1'b0);
        chk("hw_two", 32'(high_water), 2);

        // Reset mid-stream with a concurrent write
        cyc(1'b1, 16'd52, 1'b0, 1'b0);
        cyc(1'b1, 16'd53, 1'b0, 1'b0);
        chk("mid_count", 32'(count), 4);
        rst_n = 1'b0;
        cyc(1'b1, 16'd77, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk_reset_state("midrst");
        cyc(1'b1, 16'd123, 1'b0, 1'b0);
        chk("post_count", 32'(count), 1);
        chk("post_hw", 32'(high_water), 1);
        rd_expect("post", 16'd123);
        chk("post_empty", 32'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
